// File: rtl/rf_pkg.sv
// Shared constants and types for the RF access sequencer.
//   NREG : number of architectural registers
//   AW   : register address width
//   DW   : data width
//   state_e : sequencer state (IDLE -> READ -> LATCH -> OUT)
package rf_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Bundle of decode, writeback, register-file and execute signals around
// rf_access_ctrl.
//   slave  : view of the sequencer itself
//   master : view of the surrounding pipeline (decode, wb, RF, execute)
// Signals:
//   iss_*  : decode issue handshake and operand/dest addresses
//   wb_*   : writeback request handshake, dest, data, high/low select
//   rf_*   : register-file read/write address, write data/enable, read data
//   ex_*   : operands and dest handed to execute with valid/ready
//   sb_busy: pending-writeback scoreboard, one bit per register
interface rf_access_ctrl_if;
  import rf_pkg::*;

  logic            iss_valid;
  logic            iss_ready;
  logic [AW-1:0]   iss_rs1;
  logic [AW-1:0]   iss_rs2;
  logic [AW-1:0]   iss_rd;
  logic            iss_wr;

  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            wb_hl;

  logic [AW-1:0]   rf_reg_port1;
  logic [AW-1:0]   rf_reg_port2;
  logic [AW-1:0]   rf_write_reg;
  logic [DW-1:0]   rf_data_in;
  logic            rf_we;
  logic            rf_hl;
  logic [DW-1:0]   rf_out1;
  logic [DW-1:0]   rf_out2;
  logic [DW-1:0]   rf_out3;

  logic            ex_valid;
  logic            ex_ready;
  logic [DW-1:0]   ex_op1;
  logic [DW-1:0]   ex_op2;
  logic [DW-1:0]   ex_op3;
  logic [AW-1:0]   ex_rd;
  logic            ex_wr;

  logic [NREG-1:0] sb_busy;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    input  wb_valid, wb_rd, wb_data, wb_hl,
    input  rf_out1, rf_out2, rf_out3,
    input  ex_ready,
    output iss_ready, wb_ready,
    output rf_reg_port1, rf_reg_port2, rf_write_reg, rf_data_in, rf_we, rf_hl,
    output ex_valid, ex_op1, ex_op2, ex_op3, ex_rd, ex_wr,
    output sb_busy
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    output wb_valid, wb_rd, wb_data, wb_hl,
    output rf_out1, rf_out2, rf_out3,
    output ex_ready,
    input  iss_ready, wb_ready,
    input  rf_reg_port1, rf_reg_port2, rf_write_reg, rf_data_in, rf_we, rf_hl,
    input  ex_valid, ex_op1, ex_op2, ex_op3, ex_rd, ex_wr,
    input  sb_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one busy flop per architectural register.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, clears all busy bits
//   set_i      : mark register set_idx_i busy
//   set_idx_i  : register to mark
//   clr_i      : clear busy for register clr_idx_i
//   clr_idx_i  : register to clear
//   busy_o     : registered busy vector
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  logic [AW-1:0]   set_idx_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_idx_i,
  output logic [NREG-1:0] busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-cycle set/clear of one register
  // leaves it busy: the new writer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (clr_i && (clr_idx_i == AW'(i))) busy_d[i] = 1'b0;
      if (set_i && (set_idx_i == AW'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequencer between decode and the register file. Each accepted instruction
// takes four cycles: READ drives its addresses to the RF, LATCH captures the
// RF's registered outputs as operands, OUT presents them to execute until
// taken. Writebacks go to the RF in any cycle except READ, and a scoreboard
// of pending writes blocks issue on RAW/WAW hazards.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : decode/writeback/RF/execute signals (slave view)
module rf_access_ctrl
  import rf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rf_access_ctrl_if.slave bus
);

  state_e          state_q;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [AW-1:0]   rd_q;
  logic            wr_q;
  logic            ex_valid_q;
  logic [DW-1:0]   ex_op1_q;
  logic [DW-1:0]   ex_op2_q;
  logic [DW-1:0]   ex_op3_q;
  logic [AW-1:0]   ex_rd_q;
  logic            ex_wr_q;

  logic [NREG-1:0] busy;
  logic            iss_ok;
  logic            wb_ok;
  logic            iss_fire;
  logic            wb_fire;

  // Hazard check uses only the registered busy vector, so a writeback
  // releases a waiting instruction one cycle later, after the RF write.
  assign iss_ok   = (state_q == IDLE) & ~busy[bus.iss_rs1]
                                      & ~busy[bus.iss_rs2]
                                      & ~busy[bus.iss_rd];
  assign wb_ok    = (state_q != READ);
  assign iss_fire = bus.iss_valid & iss_ok;
  assign wb_fire  = bus.wb_valid & wb_ok;

  rf_scoreboard u_sb (
    .clk_i     (clk),
    .rst_ni    (reset),
    .set_i     (iss_fire & bus.iss_wr),
    .set_idx_i (bus.iss_rd),
    .clr_i     (wb_fire),
    .clr_idx_i (bus.wb_rd),
    .busy_o    (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wr_q       <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_op3_q   <= '0;
      ex_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iss_fire) begin
            rs1_q   <= bus.iss_rs1;
            rs2_q   <= bus.iss_rs2;
            rd_q    <= bus.iss_rd;
            wr_q    <= bus.iss_wr;
            state_q <= READ;
          end
        end
        READ: state_q <= LATCH;
        LATCH: begin
          // RF outputs here were registered at the end of READ; a write
          // during LATCH does not change them.
          ex_op1_q   <= bus.rf_out1;
          ex_op2_q   <= bus.rf_out2;
          ex_op3_q   <= bus.rf_out3;
          ex_rd_q    <= rd_q;
          ex_wr_q    <= wr_q;
          ex_valid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.iss_ready    = iss_ok;
  assign bus.wb_ready     = wb_ok;
  assign bus.rf_reg_port1 = rs1_q;
  assign bus.rf_reg_port2 = rs2_q;
  // Third read port shares the write address; READ owns it, writeback
  // owns it otherwise.
  assign bus.rf_write_reg = (state_q == READ) ? rd_q : bus.wb_rd;
  assign bus.rf_data_in   = bus.wb_data;
  assign bus.rf_we        = wb_fire;
  assign bus.rf_hl        = bus.wb_hl;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_op1       = ex_op1_q;
  assign bus.ex_op2       = ex_op2_q;
  assign bus.ex_op3       = ex_op3_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_wr        = ex_wr_q;
  assign bus.sb_busy      = busy;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural register file.
// Expected execute handoffs are queued when an instruction is issued and
// checked by an independent monitor at each ex_valid&ex_ready.
module tb_rf_access_ctrl;
  import rf_pkg::*;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic [3:0]  rd;
    logic        wr;
  } exp_t;

  logic        clk;
  logic        reset;
  int          checks   = 0;
  int          failures = 0;
  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] mem [16];

  rf_access_ctrl_if bus ();

  rf_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: registered reads, outputs held during a write cycle.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h11;
      bus.rf_out1 <= '0;
      bus.rf_out2 <= '0;
      bus.rf_out3 <= '0;
    end else if (bus.rf_we) begin
      mem[bus.rf_write_reg] <= bus.rf_data_in;
    end else begin
      bus.rf_out1 <= mem[bus.rf_reg_port1];
      bus.rf_out2 <= mem[bus.rf_reg_port2];
      bus.rf_out3 <= mem[bus.rf_write_reg];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3,
                      input logic [3:0] d, input logic w);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.op3 = o3; e.rd = d; e.wr = w;
    expq.push_back(e);
  endtask

  // Monitor: every execute handoff must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.ex_valid && bus.ex_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ex_unexpected got op1=%h expected no handoff", bus.ex_op1);
        end else begin
          mon_e = expq.pop_front();
          chk("ex_op1", bus.ex_op1, mon_e.op1);
          chk("ex_op2", bus.ex_op2, mon_e.op2);
          chk("ex_op3", bus.ex_op3, mon_e.op3);
          chk("ex_rd",  32'(bus.ex_rd), 32'(mon_e.rd));
          chk("ex_wr",  32'(bus.ex_wr), 32'(mon_e.wr));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction and hold it until accepted (bounded).
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
    int n = 0;
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = a;
    bus.iss_rs2   = b;
    bus.iss_rd    = d;
    bus.iss_wr    = w;
    @(negedge clk);
    while (!bus.iss_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("iss_accept", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.ex_valid && n < 10) begin
      tick();
      n++;
    end
    chk("ex_valid_wait", 32'(bus.ex_valid), 32'd1);
  endtask

  task automatic handshake();
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.iss_rd    = '0;
    bus.iss_wr    = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.wb_hl     = 1'b0;
    bus.ex_ready  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_sb_busy",   32'(bus.sb_busy), 32'd0);
    chk("rst_ex_op1",    bus.ex_op1, 32'd0);
    chk("rst_ex_rd",     32'(bus.ex_rd), 32'd0);
    chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("rst_wb_ready",  32'(bus.wb_ready), 32'd1);
    chk("rst_port1",     32'(bus.rf_reg_port1), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 1: basic read, latency and hold while execute stalls
    push(32'h11, 32'h22, 32'h33, 4'd3, 1'b0);
    issue(4'd1, 4'd2, 4'd3, 1'b0);
    @(negedge clk);
    chk("t1_read_valid", 32'(bus.ex_valid), 32'd0);
    chk("t1_read_port1", 32'(bus.rf_reg_port1), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_latch_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_out_valid", 32'(bus.ex_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("t1_hold_valid", 32'(bus.ex_valid), 32'd1);
      chk("t1_hold_op1", bus.ex_op1, 32'h11);
      chk("t1_hold_op3", bus.ex_op3, 32'h33);
    end
    tick();
    handshake();
    @(negedge clk);
    chk("t1_idle_valid", 32'(bus.ex_valid), 32'd0);

    // 2: writeback offered during READ is deferred to LATCH
    tick();
    push(32'h11, 32'h22, 32'h33, 4'd3, 1'b0);
    issue(4'd1, 4'd2, 4'd3, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd4;
    bus.wb_data  = 32'hA5A5A5A5;
    bus.wb_hl    = 1'b1;
    @(negedge clk);
    chk("t2_read_wb_ready", 32'(bus.wb_ready), 32'd0);
    chk("t2_read_we",       32'(bus.rf_we), 32'd0);
    chk("t2_read_wreg",     32'(bus.rf_write_reg), 32'd3);
    chk("t2_hl",            32'(bus.rf_hl), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_latch_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("t2_latch_we",       32'(bus.rf_we), 32'd1);
    chk("t2_latch_wreg",     32'(bus.rf_write_reg), 32'd4);
    chk("t2_latch_data",     bus.rf_data_in, 32'hA5A5A5A5);
    chk("t2_mem4_before",    mem[4], 32'h44);
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_hl    = 1'b0;
    @(negedge clk);
    chk("t2_mem4_after", mem[4], 32'hA5A5A5A5);
    chk("t2_out_valid",  32'(bus.ex_valid), 32'd1);
    tick();
    handshake();

    // 3: RAW hazard on r5 held until its writeback
    push(32'h0, 32'h0, 32'h55, 4'd5, 1'b1);
    issue(4'd0, 4'd0, 4'd5, 1'b1);
    wait_valid();
    handshake();
    @(negedge clk);
    chk("t3_busy5", 32'(bus.sb_busy), 32'h0020);
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = 4'd5;
    bus.iss_rs2   = 4'd0;
    bus.iss_rd    = 4'd6;
    bus.iss_wr    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall", 32'(bus.iss_ready), 32'd0);
      tick();
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd5;
    bus.wb_data  = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_stall_wb_cycle", 32'(bus.iss_ready), 32'd0);
    chk("t3_wb_we",          32'(bus.rf_we), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    push(32'hDEADBEEF, 32'h0, 32'h66, 4'd6, 1'b0);
    @(negedge clk);
    chk("t3_released", 32'(bus.iss_ready), 32'd1);
    chk("t3_busy_clr", 32'(bus.sb_busy), 32'd0);
    tick();
    bus.iss_valid = 1'b0;
    wait_valid();
    handshake();

    // 4: writeback in OUT leaves captured operand alone
    push(32'h11, 32'h0, 32'h0, 4'd0, 1'b0);
    issue(4'd1, 4'd0, 4'd0, 1'b0);
    wait_valid();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd1;
    bus.wb_data  = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t4_out_wb_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_op1_held", bus.ex_op1, 32'h11);
    chk("t4_mem1",     mem[1], 32'hFFFFFFFF);
    tick();
    handshake();
    push(32'hFFFFFFFF, 32'h0, 32'h0, 4'd0, 1'b0);
    issue(4'd1, 4'd0, 4'd0, 1'b0);
    wait_valid();
    handshake();
    chk("t4_expq_drained", 32'(expq.size()), 32'd0);

    // 5: writeback to idle register, then same-cycle set/clear of r5
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd7;
    bus.wb_data  = 32'h12345678;
    @(negedge clk);
    chk("t5_we_r7",   32'(bus.rf_we), 32'd1);
    chk("t5_busy_r7", 32'(bus.sb_busy), 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("t5_mem7",       mem[7], 32'h12345678);
    chk("t5_busy_after", 32'(bus.sb_busy), 32'd0);
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = 4'd0;
    bus.iss_rs2   = 4'd0;
    bus.iss_rd    = 4'd5;
    bus.iss_wr    = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 4'd5;
    bus.wb_data   = 32'h5555AAAA;
    @(negedge clk);
    chk("t5_iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("t5_wb_ready",  32'(bus.wb_ready), 32'd1);
    push(32'h0, 32'h0, 32'h5555AAAA, 4'd5, 1'b1);
    tick();
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    @(negedge clk);
    chk("t5_set_wins", 32'(bus.sb_busy), 32'h0020);

    // 6: asynchronous reset while presenting operands
    wait_valid();
    #1 reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.ex_valid), 32'd0);
    chk("t6_async_busy",  32'(bus.sb_busy), 32'd0);
    chk("t6_async_op3",   bus.ex_op3, 32'd0);
    expq.delete();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("t6_valid_low", 32'(bus.ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
